keypad_code_transmitter: RTL and testbench
==========================================

KEYPAD_CODE_TRANSMITTER -- requirements
Module: keypad_code_transmitter

Parameters
REQ-001 The block SHALL have parameter MAX_FAILS, default 3, meaning the number of consecutive rejected codes that triggers lockout (legal range 1..3).
REQ-002 The block SHALL have parameter LOCKOUT_CYCLES, default 16'd1000, meaning the lockout duration in clk cycles (legal range 1..65535).

Interface
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port key_valid, input, 1 bit: keypad strobe; it is sampled only while key_ready=1.
REQ-006 The block SHALL have port key_code, input, 4 bits: 4'h0-4'hD is a digit, 4'hE is clear (*), 4'hF is enter (#).
REQ-007 The block SHALL have port door_unlocked, input, 1 bit: verdict fed back from the code-checking receiver.
REQ-008 The block SHALL have port key_ready, output, 1 bit: high when a key press is accepted this cycle.
REQ-009 The block SHALL have port digit_out, output, 4 bits: digit being transmitted to the receiver.
REQ-010 The block SHALL have port digit_valid, output, 1 bit: digit_out is valid this cycle.
REQ-011 The block SHALL have port submit, output, 1 bit: single-cycle pulse that asks the receiver to check the code.
REQ-012 The block SHALL have port locked_out, output, 1 bit: high while lockout is active.
REQ-013 The block SHALL have port fail_count, output, 2 bits: number of consecutive rejected codes.
REQ-014 The block SHALL have port busy, output, 1 bit: high in every state except COLLECT.

Function
REQ-015 The block SHALL implement five states: COLLECT, SEND, SUBMIT, WAIT_RESULT and LOCKOUT.
REQ-016 The block SHALL drive key_ready=1 only in COLLECT; in all other states key_valid SHALL be ignored and no key SHALL be buffered.
REQ-017 In COLLECT, on a digit key with count<4, the block SHALL store the digit in buffer slot [count] and increment count; a digit key with count==4 SHALL be dropped without changing state.
REQ-018 In COLLECT, on a clear key, the block SHALL set count to 0 and stay in COLLECT.
REQ-019 In COLLECT, on an enter key with count==4, the block SHALL go to SEND; on an enter key with count<4, it SHALL set count to 0, stay in COLLECT and transmit nothing.
REQ-020 In SEND, the block SHALL hold digit_valid=1 for exactly 4 consecutive cycles, with digit_out = slot 0, 1, 2, 3 (first-entered digit first), then go to SUBMIT.
REQ-021 In SUBMIT, the block SHALL drive submit=1 and digit_valid=0 for exactly one cycle, set count to 0, then go to WAIT_RESULT.
REQ-022 WAIT_RESULT SHALL last one cycle, in which the block samples door_unlocked.
REQ-023 If door_unlocked=1 in WAIT_RESULT, the block SHALL set fail_count to 0 and go to COLLECT.
REQ-024 If door_unlocked=0 in WAIT_RESULT, the block SHALL increment fail_count; if the new value equals MAX_FAILS it SHALL load the timer with LOCKOUT_CYCLES and go to LOCKOUT, otherwise it SHALL go to COLLECT.
REQ-025 In LOCKOUT, the block SHALL hold locked_out=1 and decrement the timer by 1 per cycle; when the timer reaches 0 it SHALL set fail_count to 0, drive locked_out=0 and go to COLLECT, for exactly LOCKOUT_CYCLES cycles of locked_out=1.
REQ-026 Latency: if enter is accepted in cycle T, the block SHALL produce digit_valid in T+1..T+4, submit in T+5, sample door_unlocked in T+6, and drive key_ready=1 in T+7 (if not locked out).
REQ-027 Outside SEND, the block SHALL drive digit_out=4'h0 and digit_valid=0; submit SHALL be 0 outside SUBMIT.
REQ-028 fail_count SHALL saturate at MAX_FAILS and SHALL never wrap.
REQ-029 The timer SHALL be 16 bits wide and SHALL never underflow.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 When reset=1 at a clock edge, the block SHALL enter COLLECT in the next cycle and clear count, buffer, timer and fail_count to 0, with key_ready=1, digit_valid=0, digit_out=4'h0, submit=0, locked_out=0 and busy=0.
REQ-032 Reset SHALL take priority over all inputs in every state, including mid-SEND and LOCKOUT, and SHALL not emit a partial digit or a submit.

Verification
REQ-033 Bench SHALL cover: keys 9,2,C,7,F with door_unlocked=1 in WAIT_RESULT -> digit_out 9,2,C,7 on 4 consecutive digit_valid cycles, then submit for 1 cycle, fail_count=0, key_ready back at T+7.
REQ-034 Bench SHALL cover: 3 wrong 4-digit entries with door_unlocked=0 -> fail_count 1, then 2, then locked_out=1 for exactly LOCKOUT_CYCLES cycles; keys pressed during lockout are ignored; afterwards fail_count=0.
REQ-035 Bench SHALL cover: keys 1,2,E,3,4,5,6,F -> only 3,4,5,6 are transmitted.
REQ-036 Bench SHALL cover: keys 1,2,3,4,5,F -> 1,2,3,4 are transmitted; keys 1,2,3,F -> no digit_valid and no submit, count=0.
REQ-037 Bench SHALL cover: reset asserted during the 2nd SEND cycle -> digit_valid=0 and submit=0 from the next cycle, COLLECT state, fail_count=0.
REQ-038 Bench SHALL cover: key_valid held high through SEND, SUBMIT and WAIT_RESULT -> no key is buffered and count=0 on return to COLLECT.

Source files
------------

// File: rtl/keypad_code_transmitter.sv
// Keypad front end: collects a 4-digit code, streams it to the checking receiver,
// submits it, and enforces a lockout after repeated rejected codes.
`timescale 1ns/1ps
module keypad_code_transmitter #(
    parameter int unsigned MAX_FAILS      = 3,
    parameter logic [15:0] LOCKOUT_CYCLES = 16'd1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       door_unlocked,
    output logic       key_ready,
    output logic [3:0] digit_out,
    output logic       digit_valid,
    output logic       submit,
    output logic       locked_out,
    output logic [1:0] fail_count,
    output logic       busy
);
    typedef enum logic [2:0] {
        StCollect,
        StSend,
        StSubmit,
        StWaitResult,
        StLockout
    } state_e;

    localparam logic [1:0] MaxFails = 2'(MAX_FAILS);

    state_e      state_q;
    logic [2:0]  count_q;
    logic [3:0]  buf_q [4];
    logic [1:0]  send_idx_q;
    logic [15:0] timer_q;
    logic [1:0]  fails_inc;

    assign fails_inc = (fail_count == MaxFails) ? fail_count : fail_count + 2'd1;

    // Every output is a register written alongside the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StCollect;
            count_q     <= 3'd0;
            for (int i = 0; i < 4; i++) buf_q[i] <= 4'h0;
            send_idx_q  <= 2'd0;
            timer_q     <= 16'd0;
            key_ready   <= 1'b1;
            digit_out   <= 4'h0;
            digit_valid <= 1'b0;
            submit      <= 1'b0;
            locked_out  <= 1'b0;
            fail_count  <= 2'd0;
            busy        <= 1'b0;
        end else begin
            case (state_q)
                StCollect: begin
                    if (key_valid) begin
                        if (key_code <= 4'hD) begin
                            if (count_q < 3'd4) begin
                                buf_q[count_q[1:0]] <= key_code;
                                count_q             <= count_q + 3'd1;
                            end
                        end else if (key_code == 4'hE) begin
                            count_q <= 3'd0;
                        end else if (count_q == 3'd4) begin
                            state_q     <= StSend;
                            key_ready   <= 1'b0;
                            busy        <= 1'b1;
                            digit_valid <= 1'b1;
                            digit_out   <= buf_q[0];
                            send_idx_q  <= 2'd1;
                        end else begin
                            count_q <= 3'd0;
                        end
                    end
                end
                StSend: begin
                    // send_idx_q wraps to 0 once slot 3 is on the bus.
                    if (send_idx_q == 2'd0) begin
                        state_q     <= StSubmit;
                        digit_valid <= 1'b0;
                        digit_out   <= 4'h0;
                        submit      <= 1'b1;
                    end else begin
                        digit_out  <= buf_q[send_idx_q];
                        send_idx_q <= send_idx_q + 2'd1;
                    end
                end
                StSubmit: begin
                    state_q <= StWaitResult;
                    submit  <= 1'b0;
                    count_q <= 3'd0;
                end
                StWaitResult: begin
                    if (door_unlocked) begin
                        fail_count <= 2'd0;
                        state_q    <= StCollect;
                        key_ready  <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        fail_count <= fails_inc;
                        if (fails_inc == MaxFails) begin
                            state_q    <= StLockout;
                            timer_q    <= LOCKOUT_CYCLES;
                            locked_out <= 1'b1;
                        end else begin
                            state_q   <= StCollect;
                            key_ready <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end
                end
                StLockout: begin
                    if (timer_q <= 16'd1) begin
                        timer_q    <= 16'd0;
                        locked_out <= 1'b0;
                        fail_count <= 2'd0;
                        state_q    <= StCollect;
                        key_ready  <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                default: begin
                    state_q   <= StCollect;
                    key_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_code_transmitter.sv
// Bench for keypad_code_transmitter: a timeline model of expected outputs checked
// every cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_keypad_code_transmitter;
    localparam int unsigned MAX_FAILS      = 3;
    localparam logic [15:0] LOCKOUT_CYCLES = 16'd1000;
    localparam int KIdle = 0, KSend = 1, KSubmit = 2, KWait = 3, KLock = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       door_unlocked = 1'b0;
    logic       key_ready, digit_valid, submit, locked_out, busy;
    logic [3:0] digit_out;
    logic [1:0] fail_count;

    int n_cmp = 0;
    int n_bad = 0;
    bit armed = 1'b0;

    typedef struct {
        int         kind;
        logic [3:0] dig;
    } rec_t;

    rec_t       sched[$];
    logic [3:0] entry[$];
    int         fails = 0;
    int         cur_kind = KIdle;
    logic [3:0] cur_dig = 4'h0;

    always #5 clk = ~clk;

    keypad_code_transmitter #(
        .MAX_FAILS      (MAX_FAILS),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .door_unlocked (door_unlocked),
        .key_ready     (key_ready),
        .digit_out     (digit_out),
        .digit_valid   (digit_valid),
        .submit        (submit),
        .locked_out    (locked_out),
        .fail_count    (fail_count),
        .busy          (busy)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: while idle, keys build an entry; an accepted code schedules a fixed
    // timeline of future output records, extended by a lockout on the last failure.
    initial begin
        rec_t r;
        forever begin
            @(posedge clk);
            if (reset) begin
                sched.delete();
                entry.delete();
                fails    = 0;
                cur_kind = KIdle;
                cur_dig  = 4'h0;
                armed    = 1'b1;
            end else begin
                if (cur_kind == KIdle) begin
                    if (key_valid) begin
                        if (key_code <= 4'hD) begin
                            if (entry.size() < 4) entry.push_back(key_code);
                        end else if (key_code == 4'hE) begin
                            entry.delete();
                        end else begin
                            if (entry.size() == 4) begin
                                for (int i = 0; i < 4; i++) sched.push_back('{KSend, entry[i]});
                                sched.push_back('{KSubmit, 4'h0});
                                sched.push_back('{KWait, 4'h0});
                            end
                            entry.delete();
                        end
                    end
                end else if (cur_kind == KWait) begin
                    if (door_unlocked) begin
                        fails = 0;
                    end else begin
                        if (fails < int'(MAX_FAILS)) fails = fails + 1;
                        if (fails == int'(MAX_FAILS))
                            for (int i = 0; i < int'(LOCKOUT_CYCLES); i++)
                                sched.push_back('{KLock, 4'h0});
                    end
                end else if (cur_kind == KLock && sched.size() == 0) begin
                    fails = 0;
                end
                if (sched.size() > 0) begin
                    r        = sched.pop_front();
                    cur_kind = r.kind;
                    cur_dig  = r.dig;
                end else begin
                    cur_kind = KIdle;
                    cur_dig  = 4'h0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                chk("m_key_ready", 16'(key_ready), 16'(cur_kind == KIdle));
                chk("m_busy", 16'(busy), 16'(cur_kind != KIdle));
                chk("m_digit_valid", 16'(digit_valid), 16'(cur_kind == KSend));
                chk("m_digit_out", 16'(digit_out), 16'((cur_kind == KSend) ? cur_dig : 4'h0));
                chk("m_submit", 16'(submit), 16'(cur_kind == KSubmit));
                chk("m_locked_out", 16'(locked_out), 16'(cur_kind == KLock));
                chk("m_fail_count", 16'(fail_count), 16'(fails));
            end
        end
    end

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic press4(input logic [15:0] d);
        for (int i = 0; i < 4; i++) press(d[4*(3-i) +: 4]);
    endtask

    // Called at the negedge of T+1; returns at the negedge of T+7.
    task automatic expect_tx(input string name, input logic [15:0] d);
        for (int i = 0; i < 4; i++) begin
            chk({name, "_dv"}, 16'(digit_valid), 16'd1);
            chk({name, "_dout"}, 16'(digit_out), 16'(d[4*(3-i) +: 4]));
            @(negedge clk);
        end
        chk({name, "_submit"}, 16'(submit), 16'd1);
        chk({name, "_dv_off"}, 16'(digit_valid), 16'd0);
        @(negedge clk);
        chk({name, "_wait_busy"}, 16'(busy), 16'd1);
        chk({name, "_wait_submit"}, 16'(submit), 16'd0);
        @(negedge clk);
    endtask

    task automatic expect_none(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            chk({name, "_dv"}, 16'(digit_valid), 16'd0);
            chk({name, "_submit"}, 16'(submit), 16'd0);
            chk({name, "_ready"}, 16'(key_ready), 16'd1);
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_key_ready", 16'(key_ready), 16'd1);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_dv", 16'(digit_valid), 16'd0);
        chk("rst_dout", 16'(digit_out), 16'd0);
        chk("rst_submit", 16'(submit), 16'd0);
        chk("rst_locked", 16'(locked_out), 16'd0);
        chk("rst_fails", 16'(fail_count), 16'd0);

        // Accepted code, latency pinned.
        door_unlocked = 1'b1;
        press4(16'h92C7);
        press(4'hF);
        expect_tx("ok", 16'h92C7);
        chk("ok_ready_t7", 16'(key_ready), 16'd1);
        chk("ok_fails", 16'(fail_count), 16'd0);

        // Three rejections lead to lockout.
        door_unlocked = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            press4(16'h1111);
            press(4'hF);
            expect_tx("bad", 16'h1111);
            chk("bad_fails", 16'(fail_count), 16'(e));
            chk("bad_locked", 16'(locked_out), (e == 3) ? 16'd1 : 16'd0);
        end
        n = 0;
        while (locked_out === 1'b1 && n < 2000) begin
            n++;
            key_valid = 1'b1;
            key_code  = (n % 4 == 0) ? 4'hF : 4'h5;
            @(negedge clk);
        end
        key_valid = 1'b0;
        chk("lock_len", 16'(n), LOCKOUT_CYCLES);
        chk("lock_fails_after", 16'(fail_count), 16'd0);
        chk("lock_ready_after", 16'(key_ready), 16'd1);
        press(4'hF);
        expect_none("lock_noleak", 8);

        // Clear discards earlier digits.
        door_unlocked = 1'b1;
        press(4'h1);
        press(4'h2);
        press(4'hE);
        press4(16'h3456);
        press(4'hF);
        expect_tx("clr", 16'h3456);

        // Fifth digit dropped; short entry sends nothing and empties the buffer.
        press4(16'h1234);
        press(4'h5);
        press(4'hF);
        expect_tx("five", 16'h1234);
        press(4'h1);
        press(4'h2);
        press(4'h3);
        press(4'hF);
        expect_none("short", 8);
        press4(16'h789A);
        press(4'hF);
        expect_tx("after_short", 16'h789A);

        // Reset in the 2nd SEND cycle, with a nonzero fail count.
        door_unlocked = 1'b0;
        press4(16'h1111);
        press(4'hF);
        expect_tx("pre_rst", 16'h1111);
        chk("pre_rst_fails", 16'(fail_count), 16'd1);
        press4(16'h4321);
        press(4'hF);
        @(negedge clk);
        chk("midsend_dout", 16'(digit_out), 16'h3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_dv", 16'(digit_valid), 16'd0);
        chk("midrst_submit", 16'(submit), 16'd0);
        chk("midrst_ready", 16'(key_ready), 16'd1);
        chk("midrst_fails", 16'(fail_count), 16'd0);
        expect_none("midrst_quiet", 6);

        // key_valid held high through SEND, SUBMIT and WAIT_RESULT.
        door_unlocked = 1'b1;
        press4(16'h2468);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'hF;
        @(negedge clk);
        key_code = 4'h8;
        expect_tx("hold", 16'h2468);
        key_valid = 1'b0;
        press(4'h1);
        press(4'h2);
        press(4'h3);
        press(4'hF);
        expect_none("hold_nobuf", 8);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
